// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and constants for the 4-bit mux-scan serializer.
package mux_scan_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic [1:0] SEL_FIRST_LSB = 2'd0;
  localparam logic [1:0] SEL_LAST_LSB  = 2'd3;
  localparam int         WORD_W        = 4;

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/mux_scan_serializer_multiplexer4x1.sv
// 4:1 bit multiplexer: picks w[sel] combinationally.
module multiplexer4x1
  import mux_scan_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] w,
  input  logic [1:0]        sel,
  output logic              y
);

  always_comb begin
    y = w[0];
    case (sel)
      2'd0: y = w[0];
      2'd1: y = w[1];
      2'd2: y = w[2];
      2'd3: y = w[3];
      default: y = w[0];
    endcase
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial converter: a word register scanned by a select counter through a 4:1 mux.
// Optional trailing even-parity bit when MUX_SCAN_PARITY_EN is defined.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy
);

  localparam logic [1:0] SEL_START = LSB_FIRST ? SEL_FIRST_LSB : SEL_LAST_LSB;
  localparam logic [1:0] SEL_FINAL = LSB_FIRST ? SEL_LAST_LSB  : SEL_FIRST_LSB;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] word, word_nxt;
  logic [1:0]        sel, sel_nxt;
  logic              mux_bit;
  logic              final_bit;

  function automatic logic [1:0] sel_step(input logic [1:0] s);
    return LSB_FIRST ? s + 2'd1 : s - 2'd1;
  endfunction

  multiplexer4x1 u_mux (
    .w   (word),
    .sel (sel),
    .y   (mux_bit)
  );

  assign final_bit = (state == SHIFT) && (sel == SEL_FINAL);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    word_nxt  = word;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_out   = mux_bit;
    case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        ser_valid = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        if (ser_ready) begin
          if (final_bit) begin
            state_nxt = PAR;
            sel_nxt   = SEL_START;
          end else begin
            sel_nxt = sel_step(sel);
          end
        end
`else
        ser_last = final_bit;
        // Final bit with downstream ready frees the word slot for a zero-bubble reload.
        in_ready = final_bit && ser_ready;
        if (ser_ready) begin
          if (final_bit) begin
            state_nxt = IDLE;
            sel_nxt   = SEL_START;
          end else begin
            sel_nxt = sel_step(sel);
          end
        end
`endif
      end
`ifdef MUX_SCAN_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        ser_out   = even_parity(word);
        in_ready  = ser_ready;
        if (ser_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Acceptance overrides the end-of-word return to IDLE.
    if (in_valid && in_ready) begin
      word_nxt  = in_data;
      sel_nxt   = SEL_START;
      state_nxt = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= '0;
      sel   <= SEL_START;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      sel   <= sel_nxt;
    end
  end

endmodule
